// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM stage of the pipeline. It turns the load/store controls latched in the
// EX/MEM register into a request/grant/response handshake on the data-memory
// port. It stalls the front of the pipeline while an access is outstanding and
// registers the MEM/WB pipeline fields.
//
// Parameters
//   TIMEOUT           max cycles spent waiting in REQ or RESP before the access
//                     is aborted (only meaningful when MEM_TIMEOUT_EN is set)
//
// Optional feature
//   MEM_TIMEOUT_EN    when defined, a wait counter aborts a stuck access after
//                     TIMEOUT cycles and raises the sticky mem_fault flag.
//                     When undefined, the unit waits indefinitely and
//                     mem_fault is tied to 0.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   MEM_Branch, MEM_Zero       branch decision inputs -> PCSrc (combinational)
//   MEM_RegWrite, MEM_MemToReg writeback controls from EX/MEM
//   MEM_MemRead, MEM_MemWrite  load / store request from EX/MEM
//   MEM_ALU_result             access address / ALU result
//   MEM_Write_data             store data
//   MEM_rd                     destination register
//   dmem_req/we/addr/wdata     request side of the data-memory port
//   dmem_gnt                   memory accepted the request this cycle
//   dmem_rvalid, dmem_rdata    load response
//   stall                      freezes PC, IF/ID, ID/EX and EX/MEM
//   PCSrc                      taken branch
//   mem_fault                  sticky access-timeout flag
//   MEM_WB_*                   registered MEM/WB pipeline fields
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_Branch,
    input  logic        MEM_Zero,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemToReg,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [63:0] MEM_ALU_result,
    input  logic [63:0] MEM_Write_data,
    input  logic [4:0]  MEM_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        PCSrc,
    output logic        mem_fault,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemToReg,
    output logic [63:0] MEM_WB_Read_data,
    output logic [63:0] MEM_WB_ALU_result,
    output logic [4:0]  MEM_WB_rd
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_access;
    logic        w_isLoad;
    logic        w_isStore;
    logic        w_timeout;
    logic        w_stall;
    logic [63:0] r_loadData;

    // A simultaneous read+write is treated as a load only, so "store" means
    // write without read.
    assign w_access  = MEM_MemRead | MEM_MemWrite;
    assign w_isLoad  = MEM_MemRead;
    assign w_isStore = MEM_MemWrite & ~MEM_MemRead;

    // Branch resolution is purely combinational and independent of the FSM.
    assign PCSrc = MEM_Branch & MEM_Zero;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] r_waitCnt;
    logic          r_fault;

    // The counter holds the number of cycles already spent in the current
    // waiting state, so the TIMEOUT-th cycle without progress aborts.
    assign w_timeout = ((r_state == REQ  && !dmem_gnt) ||
                        (r_state == RESP && !dmem_rvalid)) &&
                       (r_waitCnt == CW'(TIMEOUT - 1));

    // Any state change (including REQ -> RESP) restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_waitCnt <= '0;
        end else if ((r_state == REQ || r_state == RESP) && w_nextState == r_state) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end else begin
            r_waitCnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else if (w_timeout) begin
            r_fault <= 1'b1;
        end
    end

    assign mem_fault = r_fault;
`else
    assign w_timeout = 1'b0;
    assign mem_fault = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DONE always returns to IDLE; the pipeline advances in
    // DONE, so the same instruction is never issued twice.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    w_nextState = w_isLoad ? RESP : DONE;
                end else if (w_timeout) begin
                    w_nextState = DONE;
                end
            end
            RESP: begin
                if (dmem_rvalid || w_timeout) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output logic. Address and write data are don't-care outside REQ, so
    // they pass straight through rather than being muxed.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = MEM_ALU_result;
        dmem_wdata = MEM_Write_data;
        w_stall    = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_access;
            end
            REQ: begin
                dmem_req = 1'b1;
                dmem_we  = w_isStore;
                w_stall  = 1'b1;
            end
            RESP: begin
                w_stall = 1'b1;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    assign stall = w_stall;

    // Load data is cleared when a new access starts, so an aborted load
    // writes back 0. It is only captured in RESP, never in the grant cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_loadData <= '0;
        end else if (r_state == IDLE && w_access) begin
            r_loadData <= '0;
        end else if (r_state == RESP && dmem_rvalid) begin
            r_loadData <= dmem_rdata;
        end
    end

    // MEM/WB register: inserts a bubble while stalled, otherwise captures
    // the instruction leaving the MEM stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_MemToReg   <= 1'b0;
            MEM_WB_Read_data  <= '0;
            MEM_WB_ALU_result <= '0;
            MEM_WB_rd         <= '0;
        end else if (w_stall) begin
            MEM_WB_RegWrite <= 1'b0;
        end else begin
            MEM_WB_RegWrite   <= MEM_RegWrite;
            MEM_WB_MemToReg   <= MEM_MemToReg;
            MEM_WB_Read_data  <= w_isLoad ? r_loadData : 64'd0;
            MEM_WB_ALU_result <= MEM_ALU_result;
            MEM_WB_rd         <= MEM_rd;
        end
    end

endmodule
